// File: rtl/seq_mul.sv
// Sequential shift-add multiplier, one multiplier bit per clock, valid/ready on both sides.
// Define MUL_SIGNED_EN for two's-complement operands and product.

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | W shift-add steps
// DONE  | product valid, waiting for out_ready

module seq_mul #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;

  logic [2*W-1:0] acc_next;
  logic [2*W-1:0] result;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;

  assign acc_next = mplier[0] ? acc + mcand : acc;

`ifdef MUL_SIGNED_EN
  logic sign;

  // Magnitudes are taken as unsigned W-bit values so -2^(W-1) maps to 2^(W-1) exactly.
  assign a_mag  = a[W-1] ? (~a + W'(1)) : a;
  assign b_mag  = b[W-1] ? (~b + W'(1)) : b;
  assign result = sign ? (~acc_next + (2*W)'(1)) : acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sign <= a[W-1] ^ b[W-1];
    end
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      p         <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= {{W{1'b0}}, a_mag};
            mplier   <= b_mag;
            acc      <= '0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(W - 1)) begin
            p         <= result;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul at W=4; signed-mode vectors enabled when MUL_SIGNED_EN is defined.

module tb_seq_mul;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] p;
  logic       busy;

  int vectors;
  int miscompares;
  int cyc;

  seq_mul #(.W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y);
    int sx, sy;
`ifdef MUL_SIGNED_EN
    sx = x[3] ? int'(x) - 16 : int'(x);
    sy = y[3] ? int'(y) - 16 : int'(y);
`else
    sx = int'(x);
    sy = int'(y);
`endif
    return 8'(sx * sy);
  endfunction

  // Presents operands until the DUT takes them; returns just after the accepting edge.
  task automatic accept(input logic [3:0] aa, input logic [3:0] bb);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    a = aa;
    b = bb;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    a = 'x;
    b = 'x;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    vectors += 4;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    if (p !== 8'h00) begin miscompares++; $display("FAIL reset_p got=%h exp=00", p); end
  endtask

  task automatic test_basic;
    int lat;
    accept(4'd3, 4'd5);
    vectors += 2;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_run_in_ready got=%0b exp=0", in_ready); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_run_busy got=%0b exp=1", busy); end
    wait_valid(lat);
    vectors += 3;
    if (lat !== 4) begin miscompares++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    if (p !== 8'h0F) begin miscompares++; $display("FAIL basic_p got=%h exp=0f", p); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_done_busy got=%0b exp=1", busy); end
    handshake();
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_hs_out_valid got=%0b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_hs_in_ready got=%0b exp=1", in_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_hs_busy got=%0b exp=0", busy); end
    if (p !== 8'h0F) begin miscompares++; $display("FAIL basic_p_hold got=%h exp=0f", p); end
  endtask

  task automatic test_extremes;
    int lat;
    logic [7:0] exp_ff;
`ifdef MUL_SIGNED_EN
    exp_ff = 8'h01;
`else
    exp_ff = 8'hE1;
`endif
    accept(4'd15, 4'd15);
    wait_valid(lat);
    vectors += 2;
    if (lat !== 4) begin miscompares++; $display("FAIL ext_ff_latency got=%0d exp=4", lat); end
    if (p !== exp_ff) begin miscompares++; $display("FAIL ext_ff_p got=%h exp=%h", p, exp_ff); end
    handshake();
    accept(4'd0, 4'd9);
    wait_valid(lat);
    vectors += 2;
    if (lat !== 4) begin miscompares++; $display("FAIL ext_zero_latency got=%0d exp=4", lat); end
    if (p !== 8'h00) begin miscompares++; $display("FAIL ext_zero_p got=%h exp=00", p); end
    handshake();
  endtask

  task automatic test_backpressure;
    int lat;
    accept(4'd6, 4'd7);
    wait_valid(lat);
    vectors++;
    if (p !== 8'h2A) begin miscompares++; $display("FAIL bp_p got=%h exp=2a", p); end
    // New operands offered during DONE must be ignored.
    in_valid = 1'b1;
    a = 4'd1;
    b = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a = 4'($urandom);
      b = 4'($urandom);
      vectors += 3;
      if (p !== 8'h2A) begin miscompares++; $display("FAIL bp_p_stable cyc=%0d got=%h exp=2a", i, p); end
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid cyc=%0d got=%0b exp=1", i, out_valid); end
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", i, in_ready); end
    end
    in_valid = 1'b0;
    handshake();
    vectors += 3;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_out_valid got=%0b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready got=%0b exp=1", in_ready); end
    if (p !== 8'h2A) begin miscompares++; $display("FAIL bp_release_p got=%h exp=2a", p); end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    accept(4'd9, 4'd9);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_run_out_valid got=%0b exp=0", out_valid); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_run_in_ready got=%0b exp=1", in_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_run_busy got=%0b exp=0", busy); end
    if (p !== 8'h00) begin miscompares++; $display("FAIL rst_run_p got=%h exp=00", p); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    accept(4'd2, 4'd7);
    wait_valid(lat);
    vectors += 2;
    if (lat !== 4) begin miscompares++; $display("FAIL rst_next_latency got=%0d exp=4", lat); end
    if (p !== 8'h0E) begin miscompares++; $display("FAIL rst_next_p got=%h exp=0e", p); end
    handshake();
  endtask

  // in_valid and out_ready held high; each accept must follow the previous by 6 cycles.
  task automatic run_stream(input int n, input bit sweep, input string tag);
    int lat;
    int prev_acc;
    int acc_c;
    bit seen;
    logic [3:0] xa, xb;
    logic [7:0] exp_p;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev_acc  = 0;
    for (int i = 0; i < n; i++) begin
      if (sweep) begin
        xa = 4'(i >> 4);
        xb = 4'(i);
      end else begin
        xa = 4'($urandom_range(0, 15));
        xb = 4'($urandom_range(0, 15));
      end
      exp_p = model(xa, xb);
      a = xa;
      b = xb;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        if (in_ready) seen = 1'b1;
        else begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      acc_c = cyc;
      a = 4'($urandom);
      b = 4'($urandom);
      if (i > 0) begin
        vectors++;
        if (acc_c - prev_acc !== 6) begin
          miscompares++;
          $display("FAIL %s_interval i=%0d got=%0d exp=6", tag, i, acc_c - prev_acc);
        end
      end
      prev_acc = acc_c;
      wait_valid(lat);
      vectors += 2;
      if (lat !== 4) begin miscompares++; $display("FAIL %s_latency i=%0d got=%0d exp=4", tag, i, lat); end
      if (p !== exp_p) begin
        miscompares++;
        $display("FAIL %s_p i=%0d a=%h b=%h got=%h exp=%h", tag, i, xa, xb, p, exp_p);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    run_stream(10, 1'b0, "b2b");
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed;
    int lat;
    logic [3:0] va [3] = '{4'hD, 4'h8, 4'h8};
    logic [3:0] vb [3] = '{4'h5, 4'h8, 4'h7};
    logic [7:0] vp [3] = '{8'hF1, 8'h40, 8'hC8};
    for (int i = 0; i < 3; i++) begin
      accept(va[i], vb[i]);
      wait_valid(lat);
      vectors += 2;
      if (lat !== 4) begin miscompares++; $display("FAIL signed_latency i=%0d got=%0d exp=4", i, lat); end
      if (p !== vp[i]) begin miscompares++; $display("FAIL signed_p i=%0d got=%h exp=%h", i, p, vp[i]); end
      handshake();
    end
    run_stream(256, 1'b1, "sweep");
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef MUL_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
